stream_rr_mux: RTL and testbench

Parametrised N-channel valid/ready stream multiplexer for the interface test suite. It merges `NUM_CH` independent data/valid/ready streams of `DATA_WIDTH` bits into one registered output stream, with round-robin arbitration and the source channel index as sideband. It extends the single data/valid/ready bundle to a configurable-width, multi-channel handshake datapath with buffering and fairness.

---
 rtl/stream_rr_mux.sv | 137 +++++++++++++
 tb/tb_stream_rr_mux.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_rr_mux.sv
// N-channel valid/ready stream mux with round-robin arbitration and a registered output.
// Define STREAM_RR_MUX_SKID_EN for a two-entry (main + skid) buffer with full throughput.
module stream_rr_mux #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int IDX_W      = $clog2(NUM_CH)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data_i,
  input  logic [NUM_CH-1:0]            in_valid_i,
  output logic [NUM_CH-1:0]            in_ready_o,
  output logic [DATA_WIDTH-1:0]        out_data_o,
  output logic [IDX_W-1:0]             out_idx_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i
);

  localparam logic [IDX_W:0] LP_N = (IDX_W+1)'(NUM_CH);

  logic [IDX_W-1:0]      r_ptr;
  logic                  r_main_vld;
  logic [DATA_WIDTH-1:0] r_main_data;
  logic [IDX_W-1:0]      r_main_idx;

  logic [2*NUM_CH-1:0]   w_rot;
  logic                  w_found;
  logic [IDX_W-1:0]      w_off;
  logic [IDX_W:0]        w_sum;
  logic [IDX_W-1:0]      w_gnt_idx;
  logic [IDX_W:0]        w_inc;
  logic [IDX_W-1:0]      w_nxt_ptr;
  logic [NUM_CH-1:0]     w_gnt_oh;
  logic [DATA_WIDTH-1:0] w_gnt_data;
  logic                  w_can_acc;
  logic                  w_acc;
  logic                  w_drain;

  // Rotate valids so that bit 0 is the channel at ptr; first set bit wins.
  always_comb begin
    w_rot   = {in_valid_i, in_valid_i} >> r_ptr;
    w_found = 1'b0;
    w_off   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!w_found && w_rot[i]) begin
        w_found = 1'b1;
        w_off   = IDX_W'(i);
      end
    end
    w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
    w_gnt_idx = (w_sum >= LP_N) ? IDX_W'(w_sum - LP_N)
                                : w_sum[IDX_W-1:0];
    w_inc     = {1'b0, w_gnt_idx} + (IDX_W+1)'(1);
    w_nxt_ptr = (w_inc == LP_N) ? '0 : w_inc[IDX_W-1:0];
    w_gnt_oh   = '0;
    w_gnt_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_gnt_idx == IDX_W'(k)) begin
        w_gnt_oh[k] = w_found;
        w_gnt_data  = in_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_drain     = r_main_vld & out_ready_i;
  assign w_acc       = w_found & w_can_acc;
  assign in_ready_o  = w_gnt_oh & {NUM_CH{w_can_acc & rst_ni}};
  assign out_valid_o = r_main_vld;
  assign out_data_o  = r_main_data;
  assign out_idx_o   = r_main_idx;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= '0;
    end else if (w_acc) begin
      r_ptr <= w_nxt_ptr;
    end
  end

`ifdef STREAM_RR_MUX_SKID_EN
  logic                  r_skid_vld;
  logic [DATA_WIDTH-1:0] r_skid_data;
  logic [IDX_W-1:0]      r_skid_idx;

  // Readiness looks only at the skid slot, never at out_ready_i.
  assign w_can_acc = ~r_skid_vld;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_main_vld  <= 1'b0;
      r_main_data <= '0;
      r_main_idx  <= '0;
      r_skid_vld  <= 1'b0;
      r_skid_data <= '0;
      r_skid_idx  <= '0;
    end else if (w_drain) begin
      if (r_skid_vld) begin
        r_main_data <= r_skid_data;
        r_main_idx  <= r_skid_idx;
        r_skid_vld  <= 1'b0;
      end else if (w_acc) begin
        r_main_data <= w_gnt_data;
        r_main_idx  <= w_gnt_idx;
      end else begin
        r_main_vld  <= 1'b0;
      end
    end else if (w_acc) begin
      if (!r_main_vld) begin
        r_main_vld  <= 1'b1;
        r_main_data <= w_gnt_data;
        r_main_idx  <= w_gnt_idx;
      end else begin
        r_skid_vld  <= 1'b1;
        r_skid_data <= w_gnt_data;
        r_skid_idx  <= w_gnt_idx;
      end
    end
  end
`else
  assign w_can_acc = ~r_main_vld;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_main_vld  <= 1'b0;
      r_main_data <= '0;
      r_main_idx  <= '0;
    end else if (w_acc) begin
      r_main_vld  <= 1'b1;
      r_main_data <= w_gnt_data;
      r_main_idx  <= w_gnt_idx;
    end else if (w_drain) begin
      r_main_vld  <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_stream_rr_mux.sv
// Scoreboard bench for stream_rr_mux (4 channels x 32 bits).
// Inputs change 1ns after the rising edge; the monitor samples on the falling edge.
module tb_stream_rr_mux;

`ifdef STREAM_RR_MUX_SKID_EN
  localparam int DEPTH = 2;
  localparam int GAP   = 1;
  localparam int TPUT  = 101;
`else
  localparam int DEPTH = 1;
  localparam int GAP   = 2;
  localparam int TPUT  = 200;
`endif

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] data;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b1;
  logic [127:0] in_data = '0;
  logic [3:0]   in_valid = '0;
  logic [3:0]   in_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_idx;
  logic         out_valid;
  logic         out_ready = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_acc = 0;
  int m_ptr = 0;
  bit acc1 = 1'b0;
  bit p_hold = 1'b0;
  logic [33:0] p_out;
  beat_t sb[$];
  int out_log[$];
  int out_cyc[$];

  stream_rr_mux #(.DATA_WIDTH(32), .NUM_CH(4)) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .in_data_i(in_data),
    .in_valid_i(in_valid),
    .in_ready_o(in_ready),
    .out_data_o(out_data),
    .out_idx_o(out_idx),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rr(input logic [3:0] v, input int p);
    for (int i = 0; i < 4; i++) begin
      if (v[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int g;
    beat_t e;
    cyc++;
    acc1 = 1'b0;
    if (!rst_ni) begin
      sb.delete();
      m_ptr  = 0;
      p_hold = 1'b0;
    end else begin
      if (p_hold) chk("hold", {out_idx, out_data}, p_out);
      p_hold = out_valid && !out_ready;
      p_out  = {out_idx, out_data};
      if (in_ready != 4'b0) begin
        g = rr(in_valid, m_ptr);
        chk("grant", in_ready, (g < 0) ? 4'b0 : (4'b1 << g));
        if (g >= 0) begin
          e.idx  = g[1:0];
          e.data = in_data[g*32 +: 32];
          sb.push_back(e);
          m_ptr = (g + 1) % 4;
          n_acc++;
          if (g == 1) acc1 = 1'b1;
        end
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_idx", out_idx, e.idx);
        end
        out_log.push_back(int'(out_idx));
        out_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    out_log.delete();
    out_cyc.delete();
    n_acc = 0;
  endtask

  task automatic wait_outs(input int n, input int budget);
    int b;
    b = 0;
    while (out_log.size() < n && b < budget) begin
      tick();
      b++;
    end
    chk("out_count", out_log.size(), n);
  endtask

  initial begin
    logic [31:0] held;
    int n0;
    int c0;
    int seq[4];

    // Reset with all channels requesting.
    #2 rst_ni = 1'b0;
    in_valid = 4'hF;
    @(negedge clk);
    @(negedge clk);
    chk("rst_vld", out_valid, 0);
    chk("rst_rdy", in_ready, 4'h0);
    chk("rst_data", out_data, 0);
    chk("rst_idx", out_idx, 0);
    tick();
    rst_ni = 1'b1;
    in_valid = 4'b0100;
    in_data[64 +: 32] = 32'hA5A5_0002;
    tick();
    in_valid = 4'b0;
    @(negedge clk);
    chk("first_vld", out_valid, 1);
    chk("first_data", out_data, 32'hA5A5_0002);
    chk("first_idx", out_idx, 2);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 4'hF;
    @(negedge clk);
    chk("ptr3", in_ready, 4'b1000);

    // Fairness with all channels valid.
    in_valid = 4'b0;
    do_reset();
    for (int k = 0; k < 4; k++) in_data[k*32 +: 32] = 32'h100 + k;
    in_valid = 4'hF;
    out_ready = 1'b1;
    wait_outs(6, 40);
    in_valid = 4'b0;
    for (int i = 0; i < 6; i++) chk("fair_idx", out_log[i], i % 4);
    for (int i = 1; i < 6; i++)
      chk("fair_gap", out_cyc[i] - out_cyc[i-1], GAP);

    // Backpressure: fill, hold, then drain.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) in_data[k*32 +: 32] = 32'h200 + k;
    in_valid = 4'hF;
    repeat (4) tick();
    @(negedge clk);
    chk("bp_rdy", in_ready, 4'h0);
    chk("bp_vld", out_valid, 1);
    held = out_data;
    chk("bp_first", held, 32'h200);
    repeat (5) begin
      tick();
      @(negedge clk);
      chk("bp_data", out_data, held);
    end
    tick();
    in_valid = 4'b0;
    out_ready = 1'b1;
    n0 = out_log.size();
    wait_outs(n0 + DEPTH, 20);
    repeat (3) tick();
    chk("bp_acc", n_acc, DEPTH);
    chk("bp_sb", sb.size(), 0);
    chk("bp_empty", out_valid, 0);

    // Wrap and skip: ptr=3 after ch2, then ch0/ch2 only.
    do_reset();
    out_ready = 1'b1;
    in_data[0 +: 32]  = 32'h0000_0C00;
    in_data[64 +: 32] = 32'h0000_0C02;
    in_valid = 4'b0100;
    tick();
    in_valid = 4'b0101;
    wait_outs(4, 30);
    in_valid = 4'b0;
    seq = '{2, 0, 2, 0};
    for (int i = 0; i < 4; i++) chk("wrap_idx", out_log[i], seq[i]);

    // Asynchronous reset with a full buffer.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) in_data[k*32 +: 32] = 32'h400 + k;
    in_valid = 4'hF;
    repeat (4) tick();
    @(negedge clk);
    chk("mr_pre", out_valid, 1);
    @(posedge clk);
    #2 rst_ni = 1'b0;
    #1;
    chk("mr_vld", out_valid, 0);
    chk("mr_data", out_data, 0);
    chk("mr_rdy", in_ready, 4'h0);
    in_valid = 4'b1010;
    tick();
    rst_ni = 1'b1;
    out_log.delete();
    out_cyc.delete();
    out_ready = 1'b1;
    wait_outs(1, 10);
    chk("mr_first", out_log[0], 1);
    in_valid = 4'b0;

    // Throughput: 100 beats on ch1.
    do_reset();
    out_ready = 1'b1;
    in_data[32 +: 32] = 32'h300;
    tick();
    in_valid = 4'b0010;
    c0 = cyc;
    for (int b = 0; b < 500 && out_log.size() < 100; b++) begin
      tick();
      if (acc1) in_data[32 +: 32] = in_data[32 +: 32] + 1;
      if (n_acc >= 100) in_valid = 4'b0;
    end
    chk("tput_outs", out_log.size(), 100);
    chk("tput_acc", n_acc, 100);
    chk("tput_cyc", out_cyc[99] - c0, TPUT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
